// File: rtl/decode_reg_read.sv
// decode_reg_read: SEQ Y86-64 decode stage merged with the architectural
// register file. Decodes source/destination register IDs from the current
// instruction, returns operands combinationally from stored state, and
// commits valE/valM on the rising clock edge (M port wins on collision).
module decode_reg_read #(
    parameter int               WIDTH    = 64,
    parameter logic [WIDTH-1:0] RSP_INIT = 'h200,
    parameter int               NUM_REGS = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       icode,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic             Cnd,
    input  logic [WIDTH-1:0] valE,
    input  logic [WIDTH-1:0] valM,
    input  logic             wb_en,
    output logic [3:0]       srcA,
    output logic [3:0]       srcB,
    output logic [3:0]       dstE,
    output logic [3:0]       dstM,
    output logic [WIDTH-1:0] valA,
    output logic [WIDTH-1:0] valB,
    input  logic [3:0]       dbg_sel,
    output logic [WIDTH-1:0] dbg_val
);

    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] REG_RSP  = 4'h4;

    // Instruction codes that touch the register file
    localparam logic [3:0] I_RRMOVQ = 4'h2;  // also cmovXX
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    logic [WIDTH-1:0] r_regs [0:NUM_REGS-1];

    logic [3:0] w_src_a;
    logic [3:0] w_src_b;
    logic [3:0] w_dst_e;
    logic [3:0] w_dst_m;

    // Decode register IDs from icode/rA/rB; unlisted icodes select "none"
    always_comb begin
        w_src_a = REG_NONE;
        w_src_b = REG_NONE;
        w_dst_e = REG_NONE;
        w_dst_m = REG_NONE;
        case (icode)
            I_RRMOVQ: begin
                w_src_a = rA;
                // cmovXX only writes when the condition held
                w_dst_e = Cnd ? rB : REG_NONE;
            end
            I_IRMOVQ: begin
                w_dst_e = rB;
            end
            I_RMMOVQ: begin
                w_src_a = rA;
                w_src_b = rB;
            end
            I_MRMOVQ: begin
                w_src_b = rB;
                w_dst_m = rA;
            end
            I_OPQ: begin
                w_src_a = rA;
                w_src_b = rB;
                w_dst_e = rB;
            end
            I_CALL: begin
                w_src_b = REG_RSP;
                w_dst_e = REG_RSP;
            end
            I_RET: begin
                w_src_a = REG_RSP;
                w_src_b = REG_RSP;
                w_dst_e = REG_RSP;
            end
            I_PUSHQ: begin
                w_src_a = rA;
                w_src_b = REG_RSP;
                w_dst_e = REG_RSP;
            end
            I_POPQ: begin
                w_src_a = REG_RSP;
                w_src_b = REG_RSP;
                w_dst_e = REG_RSP;
                w_dst_m = rA;
            end
            default: begin
            end
        endcase
    end

    // Combinational reads from stored state; ID F reads as zero, no bypass
    always_comb begin
        valA    = (w_src_a == REG_NONE) ? '0 : r_regs[w_src_a];
        valB    = (w_src_b == REG_NONE) ? '0 : r_regs[w_src_b];
        dbg_val = (dbg_sel == REG_NONE) ? '0 : r_regs[dbg_sel];
    end

    assign srcA = w_src_a;
    assign srcB = w_src_b;
    assign dstE = w_dst_e;
    assign dstM = w_dst_m;

    // Register commit: reset reinitialises the file and drops any commit;
    // the M write is issued last so it overrides E when both target one reg
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= (i == 4) ? RSP_INIT : '0;
            end
        end else if (wb_en) begin
            if (w_dst_e != REG_NONE) begin
                r_regs[w_dst_e] <= valE;
            end
            if (w_dst_m != REG_NONE) begin
                r_regs[w_dst_m] <= valM;
            end
        end
    end

endmodule

// File: tb/tb_decode_reg_read.sv
// Self-checking bench for decode_reg_read: directed vector table covering
// the register-commit corner cases, a debug-port sweep after reset, and a
// randomized run compared against a behavioural register-file model.
module tb_decode_reg_read;

    localparam int          WIDTH = 64;
    localparam logic [63:0] RSP0  = 64'h0000_0000_0000_0200;

    logic             clk;
    logic             reset;
    logic [3:0]       icode;
    logic [3:0]       rA;
    logic [3:0]       rB;
    logic             Cnd;
    logic [WIDTH-1:0] valE;
    logic [WIDTH-1:0] valM;
    logic             wb_en;
    logic [3:0]       srcA;
    logic [3:0]       srcB;
    logic [3:0]       dstE;
    logic [3:0]       dstM;
    logic [WIDTH-1:0] valA;
    logic [WIDTH-1:0] valB;
    logic [3:0]       dbg_sel;
    logic [WIDTH-1:0] dbg_val;

    int total;
    int bad;

    decode_reg_read #(
        .WIDTH(WIDTH),
        .RSP_INIT(RSP0),
        .NUM_REGS(15)
    ) dut (
        .clk(clk), .reset(reset), .icode(icode), .rA(rA), .rB(rB), .Cnd(Cnd),
        .valE(valE), .valM(valM), .wb_en(wb_en),
        .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
        .valA(valA), .valB(valB), .dbg_sel(dbg_sel), .dbg_val(dbg_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        wb;
        logic [3:0]  ic;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        cnd;
        logic [63:0] ve;
        logic [63:0] vm;
        logic [3:0]  e_sa;
        logic [3:0]  e_sb;
        logic [3:0]  e_de;
        logic [3:0]  e_dm;
        logic [63:0] e_va;
        logic [63:0] e_vb;
    } vec_t;

    vec_t vecs [0:20];

    // Behavioural register file: 16 slots so ID F can be written and ignored
    logic [63:0] m_regs [0:15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] a);
        if (ic inside {4'd2, 4'd4, 4'd6, 4'd10}) return a;
        if (ic inside {4'd9, 4'd11}) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] b);
        if (ic inside {4'd4, 4'd5, 4'd6}) return b;
        if (ic inside {4'd8, 4'd9, 4'd10, 4'd11}) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] b, input logic c);
        if (ic inside {4'd3, 4'd6}) return b;
        if (ic == 4'd2) return c ? b : 4'hF;
        if (ic inside {4'd8, 4'd9, 4'd10, 4'd11}) return 4'd4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] a);
        if (ic inside {4'd5, 4'd11}) return a;
        return 4'hF;
    endfunction

    function automatic logic [63:0] m_read(input logic [3:0] id);
        return (id == 4'hF) ? 64'd0 : m_regs[id];
    endfunction

    task automatic m_commit();
        logic [3:0] de;
        logic [3:0] dm;
        de = m_dstE(icode, rB, Cnd);
        dm = m_dstM(icode, rA);
        if (reset) begin
            foreach (m_regs[k]) m_regs[k] = 64'd0;
            m_regs[4] = RSP0;
        end else if (wb_en) begin
            if (de != 4'hF) m_regs[de] = valE;
            if (dm != 4'hF) m_regs[dm] = valM;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wb_en = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic dbg_sweep(input string tag);
        for (int s = 0; s < 16; s++) begin
            logic [63:0] e;
            dbg_sel = 4'(s);
            #1;
            e = (s == 4) ? RSP0 : 64'd0;
            chk($sformatf("%s_dbg%0d", tag, s), dbg_val, e);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b0;
        icode   = 4'd0;
        rA      = 4'hF;
        rB      = 4'hF;
        Cnd     = 1'b0;
        valE    = '0;
        valM    = '0;
        wb_en   = 1'b0;
        dbg_sel = 4'hF;

        //            name       rst  wb   ic     ra     rb     cnd  valE          valM          sA     sB     dE     dM     valA                    valB
        vecs[0]  = '{"pre_opq",  1'b0,1'b0,4'd6, 4'd1, 4'd1, 1'b0,64'd0,        64'd0,        4'd1, 4'd1, 4'd1, 4'hF, 64'd0,                  64'd0};
        vecs[1]  = '{"irmov1",   1'b0,1'b1,4'd3, 4'hF, 4'd1, 1'b0,64'd45,       64'd0,        4'hF, 4'hF, 4'd1, 4'hF, 64'd0,                  64'd0};
        vecs[2]  = '{"post_irm", 1'b0,1'b0,4'd6, 4'd1, 4'd1, 1'b0,64'd0,        64'd0,        4'd1, 4'd1, 4'd1, 4'hF, 64'd45,                 64'd45};
        vecs[3]  = '{"cmov_n",   1'b0,1'b1,4'd2, 4'd0, 4'd7, 1'b0,64'd9,        64'd0,        4'd0, 4'hF, 4'hF, 4'hF, 64'd0,                  64'd0};
        vecs[4]  = '{"cmov_n_r", 1'b0,1'b0,4'd6, 4'd7, 4'd7, 1'b0,64'd0,        64'd0,        4'd7, 4'd7, 4'd7, 4'hF, 64'd0,                  64'd0};
        vecs[5]  = '{"cmov_y",   1'b0,1'b1,4'd2, 4'd0, 4'd7, 1'b1,64'd9,        64'd0,        4'd0, 4'hF, 4'd7, 4'hF, 64'd0,                  64'd0};
        vecs[6]  = '{"cmov_y_r", 1'b0,1'b0,4'd6, 4'd7, 4'd4, 1'b0,64'd0,        64'd0,        4'd7, 4'd4, 4'd4, 4'hF, 64'd9,                  RSP0};
        vecs[7]  = '{"popq_rsp", 1'b0,1'b1,4'd11,4'd4, 4'hF, 1'b0,64'h208,      64'd35,       4'd4, 4'd4, 4'd4, 4'd4, RSP0,                   RSP0};
        vecs[8]  = '{"popq_r",   1'b0,1'b0,4'd6, 4'd4, 4'd4, 1'b0,64'd0,        64'd0,        4'd4, 4'd4, 4'd4, 4'hF, 64'd35,                 64'd35};
        vecs[9]  = '{"set_r2",   1'b0,1'b1,4'd3, 4'hF, 4'd2, 1'b0,64'd5,        64'd0,        4'hF, 4'hF, 4'd2, 4'hF, 64'd0,                  64'd0};
        vecs[10] = '{"pushq",    1'b0,1'b1,4'd10,4'd2, 4'hF, 1'b0,64'h1F8,      64'd0,        4'd2, 4'd4, 4'd4, 4'hF, 64'd5,                  64'd35};
        vecs[11] = '{"mrmovq",   1'b0,1'b1,4'd5, 4'd8, 4'd4, 1'b0,64'd0,        -64'sd7,      4'hF, 4'd4, 4'hF, 4'd8, 64'd0,                  64'h1F8};
        vecs[12] = '{"mrm_r",    1'b0,1'b0,4'd6, 4'd8, 4'd4, 1'b0,64'd0,        64'd0,        4'd8, 4'd4, 4'd4, 4'hF, 64'hFFFF_FFFF_FFFF_FFF9,64'h1F8};
        vecs[13] = '{"wb_off",   1'b0,1'b0,4'd3, 4'hF, 4'd5, 1'b0,64'd99,       64'd0,        4'hF, 4'hF, 4'd5, 4'hF, 64'd0,                  64'd0};
        vecs[14] = '{"wb_off_r", 1'b0,1'b0,4'd6, 4'd5, 4'd5, 1'b0,64'd0,        64'd0,        4'd5, 4'd5, 4'd5, 4'hF, 64'd0,                  64'd0};
        vecs[15] = '{"rst_wr",   1'b1,1'b1,4'd3, 4'hF, 4'd5, 1'b0,64'd99,       64'd0,        4'hF, 4'hF, 4'd5, 4'hF, 64'd0,                  64'd0};
        vecs[16] = '{"rst_r",    1'b0,1'b0,4'd6, 4'd5, 4'd4, 1'b0,64'd0,        64'd0,        4'd5, 4'd4, 4'd4, 4'hF, 64'd0,                  RSP0};
        vecs[17] = '{"rst_clr",  1'b0,1'b0,4'd4, 4'd8, 4'd2, 1'b0,64'd0,        64'd0,        4'd8, 4'd2, 4'hF, 4'hF, 64'd0,                  64'd0};
        vecs[18] = '{"halt",     1'b0,1'b1,4'd0, 4'd3, 4'd3, 1'b1,64'd1,        64'd2,        4'hF, 4'hF, 4'hF, 4'hF, 64'd0,                  64'd0};
        vecs[19] = '{"call",     1'b0,1'b0,4'd8, 4'd3, 4'd3, 1'b0,64'd0,        64'd0,        4'hF, 4'd4, 4'd4, 4'hF, 64'd0,                  RSP0};
        vecs[20] = '{"ret",      1'b0,1'b0,4'd9, 4'd3, 4'd3, 1'b0,64'd0,        64'd0,        4'd4, 4'd4, 4'd4, 4'hF, RSP0,                   RSP0};

        do_reset();
        dbg_sweep("rst");

        // Directed table: outputs checked in the cycle before each edge
        for (int v = 0; v < 21; v++) begin
            reset = vecs[v].rst;
            wb_en = vecs[v].wb;
            icode = vecs[v].ic;
            rA    = vecs[v].ra;
            rB    = vecs[v].rb;
            Cnd   = vecs[v].cnd;
            valE  = vecs[v].ve;
            valM  = vecs[v].vm;
            @(negedge clk);
            chk({vecs[v].name, "_srcA"}, 64'(srcA), 64'(vecs[v].e_sa));
            chk({vecs[v].name, "_srcB"}, 64'(srcB), 64'(vecs[v].e_sb));
            chk({vecs[v].name, "_dstE"}, 64'(dstE), 64'(vecs[v].e_de));
            chk({vecs[v].name, "_dstM"}, 64'(dstM), 64'(vecs[v].e_dm));
            chk({vecs[v].name, "_valA"}, valA, vecs[v].e_va);
            chk({vecs[v].name, "_valB"}, valB, vecs[v].e_vb);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;

        // Halt (wb_en=1 but no destinations) left state untouched; reset again
        // and confirm the debug view of the reinitialised file
        do_reset();
        dbg_sweep("rst2");

        // Randomized run against the behavioural model
        foreach (m_regs[k]) m_regs[k] = 64'd0;
        m_regs[4] = RSP0;
        for (int n = 0; n < 400; n++) begin
            reset   = ($urandom_range(0, 39) == 0);
            wb_en   = ($urandom_range(0, 4) != 0);
            icode   = 4'($urandom_range(0, 15));
            rA      = 4'($urandom_range(0, 15));
            rB      = 4'($urandom_range(0, 15));
            Cnd     = 1'($urandom_range(0, 1));
            valE    = {$urandom, $urandom};
            valM    = {$urandom, $urandom};
            dbg_sel = 4'($urandom_range(0, 15));
            @(negedge clk);
            chk("rnd_srcA", 64'(srcA), 64'(m_srcA(icode, rA)));
            chk("rnd_srcB", 64'(srcB), 64'(m_srcB(icode, rB)));
            chk("rnd_dstE", 64'(dstE), 64'(m_dstE(icode, rB, Cnd)));
            chk("rnd_dstM", 64'(dstM), 64'(m_dstM(icode, rA)));
            chk("rnd_valA", valA, m_read(m_srcA(icode, rA)));
            chk("rnd_valB", valB, m_read(m_srcB(icode, rB)));
            chk("rnd_dbg",  dbg_val, m_read(dbg_sel));
            @(posedge clk);
            m_commit();
            #1;
        end

        // Final full-file comparison through the debug port
        reset = 1'b0;
        wb_en = 1'b0;
        for (int s = 0; s < 16; s++) begin
            dbg_sel = 4'(s);
            #1;
            chk($sformatf("final_dbg%0d", s), dbg_val, m_read(4'(s)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
